sum_tx_controller: RTL and testbench

SUM_TX_CONTROLLER -- requirements
Module: sum_tx_controller

---
 rtl/sum_tx_pkg.sv | 31 +++
 rtl/sync_edge_det.sv | 45 ++++
 rtl/sum_tx_controller.sv | 173 +++++++++++++++++
 tb/tb_sum_tx_controller.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sum_tx_pkg.sv
// Shared definitions for the sum transmitter: FSM states, ASCII constants,
// frame length and the nibble-to-ASCII helper.
package sum_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SNAP,
      START,
      WAIT_ACK,
      WAIT_DONE,
      NEXT
   } state_t;

   localparam logic [7:0] ASCII_CR   = 8'h0D;
   localparam logic [7:0] ASCII_LF   = 8'h0A;
   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_A    = 8'h41;

   localparam int FRAME_LEN = 4;

   // Uppercase ASCII hex digit for a 4-bit value
   function automatic logic [7:0] nibble_to_hex(input logic [3:0] nibble);
      logic [7:0] wide;
      wide = {4'h0, nibble};
      if (nibble < 4'd10) begin
         return ASCII_ZERO + wide;
      end
      return ASCII_A + wide - 8'd10;
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer followed by an edge detector for one asynchronous
// control input. The edge is reported when the synchronized level moves from
// its inactive value to its active value. Edges are masked until the chain has
// been refilled with real samples after reset, so an input already sitting at
// its active level at reset release does not look like a fresh request.
module sync_edge_det #(
   parameter int SYNC_STAGES = 2,
   parameter bit ACTIVE_LOW  = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic async_in,
   output logic sync_level,
   output logic edge_pulse
);

   localparam logic IDLE_LEVEL = ACTIVE_LOW;

   logic [SYNC_STAGES-1:0] sync_ff;
   logic                   prev_level;
   logic [SYNC_STAGES:0]   fill;

   // Shift the raw input through the synchronizer, remember the previous
   // synchronized level, and track how many real samples have arrived
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_ff    <= {SYNC_STAGES{IDLE_LEVEL}};
         prev_level <= IDLE_LEVEL;
         fill       <= '0;
      end else begin
         sync_ff[0] <= async_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_ff[i] <= sync_ff[i-1];
         end
         prev_level <= sync_level;
         fill       <= {fill[SYNC_STAGES-1:0], 1'b1};
      end
   end

   assign sync_level = sync_ff[SYNC_STAGES-1];
   assign edge_pulse = fill[SYNC_STAGES]
                       && (prev_level == IDLE_LEVEL)
                       && (sync_level != IDLE_LEVEL);

endmodule

// File: rtl/sum_tx_controller.sv
// Adds two 4-bit operands captured on asynchronous save requests and, on a
// send request, transmits the sum to a UART as a 4-byte ASCII frame:
// high hex digit, low hex digit, CR, LF.
module sum_tx_controller
   import sum_tx_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int ACCEPT_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       save_a_n,
   input  logic       save_b_n,
   input  logic [3:0] data_input,
   input  logic       uart_tx_en,
   input  logic       uart_busy,
   output logic       tx_start,
   output logic [7:0] tx_data,
   output logic [4:0] sum,
   output logic       seq_busy,
   output logic       tx_err
);

   localparam logic [15:0] TIMEOUT_LAST = 16'(ACCEPT_TIMEOUT - 1);
   localparam logic [1:0]  LAST_INDEX   = 2'(FRAME_LEN - 1);

   logic        save_a_edge;
   logic        save_b_edge;
   logic        send_edge;
   logic        save_a_level;
   logic        save_b_level;
   logic        send_level;
   logic        levels_unused;

   logic [3:0]  op_a;
   logic [3:0]  op_b;
   logic [4:0]  snapshot;
   logic [1:0]  index;
   logic [15:0] timeout_cnt;
   state_t      state;

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .ACTIVE_LOW(1'b1)) u_sync_a (
      .clk        (clk),
      .reset_n    (reset_n),
      .async_in   (save_a_n),
      .sync_level (save_a_level),
      .edge_pulse (save_a_edge)
   );

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .ACTIVE_LOW(1'b1)) u_sync_b (
      .clk        (clk),
      .reset_n    (reset_n),
      .async_in   (save_b_n),
      .sync_level (save_b_level),
      .edge_pulse (save_b_edge)
   );

   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .ACTIVE_LOW(1'b0)) u_sync_send (
      .clk        (clk),
      .reset_n    (reset_n),
      .async_in   (uart_tx_en),
      .sync_level (send_level),
      .edge_pulse (send_edge)
   );

   assign levels_unused = &{save_a_level, save_b_level, send_level};

   // Byte of the frame selected by idx, built from a 5-bit sum value
   function automatic logic [7:0] frame_byte(input logic [4:0] value,
                                             input logic [1:0] idx);
      case (idx)
         2'd0:    return nibble_to_hex({3'b000, value[4]});
         2'd1:    return nibble_to_hex(value[3:0]);
         2'd2:    return ASCII_CR;
         default: return ASCII_LF;
      endcase
   endfunction

   // Operand capture: each save edge loads data_input into its operand
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_a <= '0;
         op_b <= '0;
      end else begin
         if (save_a_edge) begin
            op_a <= data_input;
         end
         if (save_b_edge) begin
            op_b <= data_input;
         end
      end
   end

   // Registered adder; 5 bits hold the full 0..30 range
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sum <= '0;
      end else begin
         sum <= {1'b0, op_a} + {1'b0, op_b};
      end
   end

   // Frame sequencer: snapshots the sum, then for each byte pulses tx_start,
   // waits for the UART to accept (busy high) and finish (busy low).
   // A UART that never accepts aborts the frame and raises tx_err.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         snapshot    <= '0;
         index       <= '0;
         timeout_cnt <= '0;
         tx_start    <= 1'b0;
         tx_data     <= '0;
         tx_err      <= 1'b0;
         seq_busy    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (send_edge) begin
                  seq_busy <= 1'b1;
                  state    <= SNAP;
               end
            end
            SNAP: begin
               snapshot <= sum;
               index    <= '0;
               tx_err   <= 1'b0;
               tx_data  <= frame_byte(sum, 2'd0);
               tx_start <= 1'b1;
               state    <= START;
            end
            START: begin
               tx_start    <= 1'b0;
               timeout_cnt <= 16'd1;
               state       <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (uart_busy) begin
                  state <= WAIT_DONE;
               end else if (timeout_cnt >= TIMEOUT_LAST) begin
                  tx_err   <= 1'b1;
                  seq_busy <= 1'b0;
                  state    <= IDLE;
               end else begin
                  timeout_cnt <= timeout_cnt + 16'd1;
               end
            end
            WAIT_DONE: begin
               if (!uart_busy) begin
                  state <= NEXT;
               end
            end
            NEXT: begin
               if (index == LAST_INDEX) begin
                  seq_busy <= 1'b0;
                  state    <= IDLE;
               end else begin
                  index    <= index + 2'd1;
                  tx_data  <= frame_byte(snapshot, index + 2'd1);
                  tx_start <= 1'b1;
                  state    <= START;
               end
            end
            default: begin
               seq_busy <= 1'b0;
               tx_start <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sum_tx_controller.sv
// Scoreboard bench for sum_tx_controller: each send request queues the bytes
// the frame should carry, and a monitor pops and compares them whenever the
// DUT pulses tx_start. A model UART raises busy for 10 cycles per byte.
module tb_sum_tx_controller;

   logic       clk;
   logic       reset_n;
   logic       save_a_n;
   logic       save_b_n;
   logic [3:0] data_input;
   logic       uart_tx_en;
   logic       uart_busy;
   logic       tx_start;
   logic [7:0] tx_data;
   logic [4:0] sum;
   logic       seq_busy;
   logic       tx_err;

   logic [7:0] exp_q[$];
   int         checks      = 0;
   int         errors      = 0;
   int         pulse_count = 0;
   bit         uart_mode   = 1'b1;

   sum_tx_controller #(.SYNC_STAGES(2), .ACCEPT_TIMEOUT(15)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .save_a_n   (save_a_n),
      .save_b_n   (save_b_n),
      .data_input (data_input),
      .uart_tx_en (uart_tx_en),
      .uart_busy  (uart_busy),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .sum        (sum),
      .seq_busy   (seq_busy),
      .tx_err     (tx_err)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model UART: one cycle after a tx_start it stays busy for 10 cycles;
   // with uart_mode cleared it never accepts anything
   initial begin
      uart_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (uart_mode && reset_n && tx_start) begin
            @(negedge clk);
            uart_busy = 1'b1;
            repeat (10) @(negedge clk);
            uart_busy = 1'b0;
         end
      end
   end

   // Monitor: every tx_start cycle consumes one expected byte
   initial begin
      logic [7:0] expected;
      forever begin
         @(negedge clk);
         if (reset_n && tx_start) begin
            pulse_count++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL unexpected_tx_start: got tx_data=0x%02h, required no pulse", tx_data);
            end else begin
               expected = exp_q.pop_front();
               if (tx_data !== expected) begin
                  errors++;
                  $display("[TB] FAIL frame_byte: got 0x%02h, required 0x%02h", tx_data, expected);
               end
            end
         end
      end
   end

   // Watchdog against a hung run
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation still running, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [7:0] actual,
                              input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%02h, required 0x%02h", name, actual, expected);
      end
   endtask

   // Drive save requests (either or both) carrying the given data
   task automatic applyStimulus(input bit do_a, input bit do_b, input logic [3:0] data);
      @(negedge clk);
      data_input = data;
      save_a_n   = ~do_a;
      save_b_n   = ~do_b;
      repeat (4) @(negedge clk);
      save_a_n = 1'b1;
      save_b_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic pulseSend();
      @(negedge clk);
      uart_tx_en = 1'b1;
      repeat (3) @(negedge clk);
      uart_tx_en = 1'b0;
   endtask

   // Queue the first n expected bytes and issue a send request
   task automatic sendRequest(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input int n);
      int waited;
      if (n > 0) exp_q.push_back(b0);
      if (n > 1) exp_q.push_back(b1);
      if (n > 2) exp_q.push_back(b2);
      if (n > 3) exp_q.push_back(b3);
      pulseSend();
      waited = 0;
      while (!seq_busy && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("frame_started", {7'd0, seq_busy}, 8'd1);
   endtask

   task automatic waitIdle(input string name);
      int waited;
      waited = 0;
      while (seq_busy && waited < 400) begin
         @(negedge clk);
         waited++;
      end
      checkOutput(name, {7'd0, seq_busy}, 8'd0);
   endtask

   task automatic waitPulses(input int target);
      int waited;
      waited = 0;
      while (pulse_count < target && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("pulse_reached", 8'(pulse_count >= target), 8'd1);
   endtask

   initial begin
      int base;
      int cycles;

      // Reset with save_a_n and uart_tx_en already active
      reset_n    = 1'b0;
      save_a_n   = 1'b0;
      save_b_n   = 1'b1;
      data_input = 4'h7;
      uart_tx_en = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_tx_start", {7'd0, tx_start}, 8'd0);
      checkOutput("reset_tx_data", tx_data, 8'h00);
      checkOutput("reset_sum", {3'd0, sum}, 8'h00);
      checkOutput("reset_seq_busy", {7'd0, seq_busy}, 8'd0);
      checkOutput("reset_tx_err", {7'd0, tx_err}, 8'd0);
      reset_n = 1'b1;
      repeat (12) @(negedge clk);
      checkOutput("no_edge_at_release_sum", {3'd0, sum}, 8'h00);
      checkOutput("no_edge_at_release_busy", {7'd0, seq_busy}, 8'd0);
      save_a_n   = 1'b1;
      uart_tx_en = 1'b0;
      repeat (6) @(negedge clk);

      // 9 + 7 = 0x10
      applyStimulus(1'b1, 1'b0, 4'h9);
      applyStimulus(1'b0, 1'b1, 4'h7);
      checkOutput("sum_9_7", {3'd0, sum}, 8'h10);
      base = pulse_count;
      sendRequest(8'h31, 8'h30, 8'h0D, 8'h0A, 4);
      waitIdle("frame_9_7_done");
      checkOutput("pulses_9_7", 8'(pulse_count - base), 8'd4);
      checkOutput("tx_err_9_7", {7'd0, tx_err}, 8'd0);

      // F + F = 0x1E
      applyStimulus(1'b1, 1'b0, 4'hF);
      applyStimulus(1'b0, 1'b1, 4'hF);
      checkOutput("sum_f_f", {3'd0, sum}, 8'h1E);
      sendRequest(8'h31, 8'h45, 8'h0D, 8'h0A, 4);
      waitIdle("frame_f_f_done");

      // 0 + 0 = 0
      applyStimulus(1'b1, 1'b0, 4'h0);
      applyStimulus(1'b0, 1'b1, 4'h0);
      checkOutput("sum_0_0", {3'd0, sum}, 8'h00);
      sendRequest(8'h30, 8'h30, 8'h0D, 8'h0A, 4);
      waitIdle("frame_0_0_done");

      // Simultaneous saves of 5 -> 0x0A
      applyStimulus(1'b1, 1'b1, 4'h5);
      checkOutput("sum_both_5", {3'd0, sum}, 8'h0A);
      sendRequest(8'h30, 8'h41, 8'h0D, 8'h0A, 4);
      waitIdle("frame_5_5_done");

      // Save during a frame: bytes keep the snapshot, sum follows operands
      applyStimulus(1'b1, 1'b0, 4'h9);
      applyStimulus(1'b0, 1'b1, 4'h7);
      checkOutput("sum_9_7_again", {3'd0, sum}, 8'h10);
      base = pulse_count;
      sendRequest(8'h31, 8'h30, 8'h0D, 8'h0A, 4);
      waitPulses(base + 2);
      applyStimulus(1'b1, 1'b0, 4'h3);
      checkOutput("sum_mid_frame", {3'd0, sum}, 8'h0A);
      waitIdle("frame_mid_save_done");
      checkOutput("pulses_mid_save", 8'(pulse_count - base), 8'd4);

      // Second send request during a frame is dropped
      base = pulse_count;
      sendRequest(8'h30, 8'h41, 8'h0D, 8'h0A, 4);
      waitPulses(base + 1);
      pulseSend();
      waitIdle("frame_double_send_done");
      repeat (40) @(negedge clk);
      checkOutput("pulses_double_send", 8'(pulse_count - base), 8'd4);
      checkOutput("idle_after_double", {7'd0, seq_busy}, 8'd0);

      // UART never accepts: tx_err exactly 15 cycles after tx_start
      uart_mode = 1'b0;
      base      = pulse_count;
      exp_q.push_back(8'h30);
      pulseSend();
      cycles = 0;
      while (!tx_start && cycles < 30) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("timeout_first_start", {7'd0, tx_start}, 8'd1);
      cycles = 0;
      while (!tx_err && cycles < 100) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("timeout_latency", 8'(cycles), 8'd15);
      checkOutput("timeout_tx_err", {7'd0, tx_err}, 8'd1);
      checkOutput("timeout_idle", {7'd0, seq_busy}, 8'd0);
      repeat (30) @(negedge clk);
      checkOutput("timeout_pulses", 8'(pulse_count - base), 8'd1);
      uart_mode = 1'b1;
      repeat (4) @(negedge clk);

      // Reset while waiting for the UART to finish the first byte
      base = pulse_count;
      sendRequest(8'h30, 8'h00, 8'h00, 8'h00, 1);
      waitPulses(base + 1);
      cycles = 0;
      while (!uart_busy && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
      repeat (2) @(negedge clk);
      checkOutput("tx_err_cleared", {7'd0, tx_err}, 8'd0);
      checkOutput("busy_before_reset", {7'd0, seq_busy}, 8'd1);
      reset_n = 1'b0;
      #1;
      checkOutput("abort_tx_start", {7'd0, tx_start}, 8'd0);
      checkOutput("abort_tx_data", tx_data, 8'h00);
      checkOutput("abort_sum", {3'd0, sum}, 8'h00);
      checkOutput("abort_seq_busy", {7'd0, seq_busy}, 8'd0);
      checkOutput("abort_tx_err", {7'd0, tx_err}, 8'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (100) @(negedge clk);
      checkOutput("no_start_after_reset", 8'(pulse_count - base), 8'd1);
      checkOutput("idle_after_reset", {7'd0, seq_busy}, 8'd0);
      checkOutput("scoreboard_drained", 8'(exp_q.size()), 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
